// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Decodes opcode/funct across several cycles and drives every datapath
// enable, mux select and the 2-bit ALU operation class. Memory accesses
// (fetch, load, store) stall on a ready handshake.
module multicycle_control (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_con_Opcode,
  input  logic [5:0] i_con_FuncCode,
  input  logic       i_con_MemReady,
  output logic       o_con_PCWrite,
  output logic       o_con_PCWriteCond,
  output logic       o_con_IorD,
  output logic       o_con_MemRead,
  output logic       o_con_MemWrite,
  output logic       o_con_MemtoReg,
  output logic       o_con_IRWrite,
  output logic       o_con_AluSrcA,
  output logic       o_con_RegWrite,
  output logic       o_con_RegDst,
  output logic [1:0] o_con_PCSource,
  output logic [1:0] o_con_AluSrcB,
  output logic [1:0] o_con_AluOp,
  output logic [3:0] o_con_State,
  output logic       o_con_Illegal
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_JR        = 4'd11,
    S_ADDI_EXEC = 4'd12,
    S_ADDI_WB   = 4'd13,
    S_TRAP      = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] FN_JR    = 6'd8;

  state_e state_q, state_d;

  // State register; reset wins over every state, including waits and TRAP.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; the combinational block below uses blocking (=).
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and output decode from the current state.
  always_comb begin
    // NOTE: every output and state_d gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    state_d           = state_q;
    o_con_PCWrite     = 1'b0;
    o_con_PCWriteCond = 1'b0;
    o_con_IorD        = 1'b0;
    o_con_MemRead     = 1'b0;
    o_con_MemWrite    = 1'b0;
    o_con_MemtoReg    = 1'b0;
    o_con_IRWrite     = 1'b0;
    o_con_AluSrcA     = 1'b0;
    o_con_RegWrite    = 1'b0;
    o_con_RegDst      = 1'b0;
    o_con_PCSource    = 2'b00;
    o_con_AluSrcB     = 2'b00;
    o_con_AluOp       = 2'b00;
    o_con_Illegal     = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        o_con_MemRead = 1'b1;
        o_con_AluSrcB = 2'b01;
        // IR and PC update only on the cycle the fetch completes.
        o_con_IRWrite = i_con_MemReady;
        o_con_PCWrite = i_con_MemReady;
        if (i_con_MemReady) state_d = S_DECODE;
      end

      S_DECODE: begin
        o_con_AluSrcB = 2'b11;  // speculative branch target into ALUOut
        if ((i_con_Opcode == OP_LW) || (i_con_Opcode == OP_SW))
          state_d = S_MEM_ADDR;
        else if (i_con_Opcode == OP_RTYPE)
          state_d = (i_con_FuncCode == FN_JR) ? S_JR : S_R_EXEC;
        else if (i_con_Opcode == OP_BEQ)  state_d = S_BRANCH;
        else if (i_con_Opcode == OP_J)    state_d = S_JUMP;
        else if (i_con_Opcode == OP_ADDI) state_d = S_ADDI_EXEC;
        else                              state_d = S_TRAP;
      end

      S_MEM_ADDR: begin
        o_con_AluSrcA = 1'b1;
        o_con_AluSrcB = 2'b10;
        state_d = (i_con_Opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end

      S_MEM_READ: begin
        o_con_MemRead = 1'b1;
        o_con_IorD    = 1'b1;
        if (i_con_MemReady) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        o_con_RegWrite = 1'b1;
        o_con_MemtoReg = 1'b1;
        state_d = S_FETCH;
      end

      S_MEM_WRITE: begin
        o_con_MemWrite = 1'b1;
        o_con_IorD     = 1'b1;
        if (i_con_MemReady) state_d = S_FETCH;
      end

      S_R_EXEC: begin
        o_con_AluSrcA = 1'b1;
        o_con_AluOp   = 2'b10;
        state_d = S_R_WB;
      end

      S_R_WB: begin
        o_con_RegDst   = 1'b1;
        o_con_RegWrite = 1'b1;
        state_d = S_FETCH;
      end

      S_BRANCH: begin
        o_con_AluSrcA     = 1'b1;
        o_con_AluOp       = 2'b01;
        o_con_PCWriteCond = 1'b1;
        o_con_PCSource    = 2'b01;
        state_d = S_FETCH;
      end

      S_JUMP: begin
        o_con_PCWrite  = 1'b1;
        o_con_PCSource = 2'b10;
        state_d = S_FETCH;
      end

      S_JR: begin
        o_con_PCWrite  = 1'b1;
        o_con_PCSource = 2'b11;
        state_d = S_FETCH;
      end

      S_ADDI_EXEC: begin
        o_con_AluSrcA = 1'b1;
        o_con_AluSrcB = 2'b10;
        state_d = S_ADDI_WB;
      end

      S_ADDI_WB: begin
        o_con_RegWrite = 1'b1;
        state_d = S_FETCH;
      end

      S_TRAP: o_con_Illegal = 1'b1;  // held until reset

      default: state_d = S_IDLE;     // unreachable codes recover to IDLE
    endcase
  end

  assign o_con_State = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the stimulus process drives one
// cycle of inputs and pushes the expected control word for that cycle; a
// monitor on the falling edge pops and compares.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       mem_ready;

  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg;
  logic       ir_write, alu_src_a, reg_write, reg_dst, illegal;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write;
    logic       mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst, illegal;
    logic [1:0] pc_source, alu_src_b, alu_op;
  } ctrl_t;

  ctrl_t sb_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  multicycle_control dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_con_Opcode     (opcode),
    .i_con_FuncCode   (funct),
    .i_con_MemReady   (mem_ready),
    .o_con_PCWrite    (pc_write),
    .o_con_PCWriteCond(pc_write_cond),
    .o_con_IorD       (iord),
    .o_con_MemRead    (mem_read),
    .o_con_MemWrite   (mem_write),
    .o_con_MemtoReg   (mem_to_reg),
    .o_con_IRWrite    (ir_write),
    .o_con_AluSrcA    (alu_src_a),
    .o_con_RegWrite   (reg_write),
    .o_con_RegDst     (reg_dst),
    .o_con_PCSource   (pc_source),
    .o_con_AluSrcB    (alu_src_b),
    .o_con_AluOp      (alu_op),
    .o_con_State      (state),
    .o_con_Illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Hand-written table of the control word required in each state.
  function automatic ctrl_t exp_of(input int st, input logic rdy);
    ctrl_t e;
    e = '0;
    e.state = 4'(st);
    case (st)
      1:  begin e.mem_read = 1; e.alu_src_b = 2'b01;
                e.ir_write = rdy; e.pc_write = rdy; end
      2:  e.alu_src_b = 2'b11;
      3:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      4:  begin e.mem_read = 1; e.iord = 1; end
      5:  begin e.reg_write = 1; e.mem_to_reg = 1; end
      6:  begin e.mem_write = 1; e.iord = 1; end
      7:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      8:  begin e.reg_dst = 1; e.reg_write = 1; end
      9:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1;
                e.pc_source = 2'b01; end
      10: begin e.pc_write = 1; e.pc_source = 2'b10; end
      11: begin e.pc_write = 1; e.pc_source = 2'b11; end
      12: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      13: e.reg_write = 1;
      15: e.illegal = 1;
      default: ;
    endcase
    return e;
  endfunction

  // One cycle: drive inputs just after the edge and queue the expected word.
  task automatic cyc(input logic r, input logic rdy, input int st);
    @(posedge clk);
    #1;
    rst       = r;
    mem_ready = rdy;
    sb_q.push_back(exp_of(st, rdy));
  endtask

  // Monitor: compare the DUT's control word against the queue head.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      ctrl_t exp_w, act;
      exp_w = sb_q.pop_front();
      act = '{state, pc_write, pc_write_cond, iord, mem_read, mem_write,
              mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst, illegal,
              pc_source, alu_src_b, alu_op};
      n_vec++;
      if (act !== exp_w) begin
        n_miss++;
        $display("FAIL vec%0d: got state=%0d word=%h, expected state=%0d word=%h",
                 n_vec, act.state, act, exp_w.state, exp_w);
      end
    end
  end

  initial begin
    rst = 1'b1; opcode = 6'd0; funct = 6'd0; mem_ready = 1'b0;

    // Reset held over two edges, then released.
    cyc(1, 0, 0);
    cyc(0, 1, 0);

    // lw: 0,1,2,3,4,5 then next fetch
    opcode = 6'd35;
    cyc(0, 1, 1); cyc(0, 1, 2); cyc(0, 1, 3); cyc(0, 1, 4); cyc(0, 1, 5);

    // sw with three wait cycles in MEM_WRITE
    cyc(0, 1, 1); opcode = 6'd43;
    cyc(0, 1, 2); cyc(0, 1, 3);
    cyc(0, 0, 6); cyc(0, 0, 6); cyc(0, 0, 6); cyc(0, 1, 6);

    // FETCH stalled two cycles, then R-type add (funct 32)
    cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 1, 1);
    opcode = 6'd0; funct = 6'd32;
    cyc(0, 0, 2); cyc(0, 0, 7); cyc(0, 0, 8);

    // jr (funct 8); MemReady low in DECODE/JR is ignored
    cyc(0, 1, 1); funct = 6'd8;
    cyc(0, 0, 2); cyc(0, 0, 11);

    // beq
    cyc(0, 1, 1); opcode = 6'd4;
    cyc(0, 1, 2); cyc(0, 1, 9);

    // j
    cyc(0, 1, 1); opcode = 6'd2;
    cyc(0, 1, 2); cyc(0, 1, 10);

    // addi
    cyc(0, 1, 1); opcode = 6'd8;
    cyc(0, 1, 2); cyc(0, 1, 12); cyc(0, 1, 13);

    // lw interrupted by reset during the MEM_READ wait
    cyc(0, 1, 1); opcode = 6'd35;
    cyc(0, 1, 2); cyc(0, 1, 3);
    cyc(0, 0, 4); cyc(1, 0, 4);
    cyc(0, 1, 0); cyc(0, 1, 1);

    // illegal opcode 63: TRAP held 10 cycles regardless of MemReady
    opcode = 6'd63;
    cyc(0, 1, 2);
    for (int i = 0; i < 9; i++) cyc(0, i[0], 15);
    cyc(1, 1, 15);
    cyc(0, 1, 0); cyc(0, 1, 1);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
